// File: rtl/stopwatch_ctrl_60.sv
// stopwatch_ctrl_60: seconds-display controller (tick prescaler, mod-60 count, idle/run/pause/lap FSM).
// Lap hold, its snapshot latch and the btn_lap path are built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl_60 #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic [3:0] q0,
  output logic [2:0] q1,
  output logic       tick,
  output logic       wrap,
  output logic [1:0] state
);

  localparam int unsigned    PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  // Button conditioning: 2-FF synchronizer, then a registered rising-edge detector.
  logic [1:0] start_sync_q;
  logic [1:0] clr_sync_q;
  logic       start_prev_q;
  logic       clr_prev_q;
  logic       ev_start_q;
  logic       ev_clr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync_q <= '0;
      clr_sync_q   <= '0;
      start_prev_q <= 1'b0;
      clr_prev_q   <= 1'b0;
      ev_start_q   <= 1'b0;
      ev_clr_q     <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[0], btn_start};
      clr_sync_q   <= {clr_sync_q[0], btn_clr};
      start_prev_q <= start_sync_q[1];
      clr_prev_q   <= clr_sync_q[1];
      ev_start_q   <= start_sync_q[1] & ~start_prev_q;
      ev_clr_q     <= clr_sync_q[1] & ~clr_prev_q;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [1:0] lap_sync_q;
  logic       lap_prev_q;
  logic       ev_lap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_sync_q <= '0;
      lap_prev_q <= 1'b0;
      ev_lap_q   <= 1'b0;
    end else begin
      lap_sync_q <= {lap_sync_q[0], btn_lap};
      lap_prev_q <= lap_sync_q[1];
      ev_lap_q   <= lap_sync_q[1] & ~lap_prev_q;
    end
  end
`else
  logic lap_unused;
  assign lap_unused = btn_lap;
`endif

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    ones_q, ones_d;
  logic [2:0]    tens_q, tens_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          counting;
`ifdef STOPWATCH_LAP_EN
  logic          snap_take;
`endif

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
`ifdef STOPWATCH_LAP_EN
    snap_take = 1'b0;
    counting  = (state_q == ST_RUN) || (state_q == ST_LAP);
`else
    counting  = (state_q == ST_RUN);
`endif

    // Counting is decided by the state before this edge, so a tick that
    // coincides with a RUN->PAUSE or RUN->LAP transition still happens.
    if (counting) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (ones_q == 4'd9) begin
          ones_d = '0;
          if (tens_q == 3'd5) begin
            tens_d = '0;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q + 3'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    // Per state, the highest-priority legal event acts; the rest are dropped.
    case (state_q)
      ST_IDLE: begin
        if (ev_clr_q) begin
          ones_d = '0;
          tens_d = '0;
        end else if (ev_start_q) begin
          state_d = ST_RUN;
          pre_d   = '0;
        end
      end
      ST_RUN: begin
        if (ev_start_q) begin
          state_d = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
        end else if (ev_lap_q) begin
          state_d   = ST_LAP;
          snap_take = 1'b1;
`endif
        end
      end
      ST_PAUSE: begin
        if (ev_clr_q) begin
          state_d = ST_IDLE;
          ones_d  = '0;
          tens_d  = '0;
          pre_d   = '0;
        end else if (ev_start_q) begin
          state_d = ST_RUN;
        end
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (ev_start_q) begin
          state_d = ST_PAUSE;
        end else if (ev_lap_q) begin
          state_d = ST_RUN;
        end
      end
`else
      ST_LAP:  state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [3:0] snap_ones_q;
  logic [2:0] snap_tens_q;

  // Snapshot takes the registered (pre-increment) live value at the LAP entry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_ones_q <= '0;
      snap_tens_q <= '0;
    end else if (snap_take) begin
      snap_ones_q <= ones_q;
      snap_tens_q <= tens_q;
    end
  end

  assign q0 = (state_q == ST_LAP) ? snap_ones_q : ones_q;
  assign q1 = (state_q == ST_LAP) ? snap_tens_q : tens_q;
`else
  assign q0 = ones_q;
  assign q1 = tens_q;
`endif

  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl_60.sv
// Scoreboard bench for stopwatch_ctrl_60 with TICK_DIV=4; lap tests run when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_ctrl_60;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_clr = 1'b0;
  logic       btn_lap = 1'b0;
  logic [3:0] q0;
  logic [2:0] q1;
  logic       tick;
  logic       wrap;
  logic [1:0] state;

  typedef struct packed {
    logic [2:0] q1;
    logic [3:0] q0;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  stopwatch_ctrl_60 #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_clr  (btn_clr),
    .btn_lap  (btn_lap),
    .q0       (q0),
    .q1       (q1),
    .tick     (tick),
    .wrap     (wrap),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected display on successive ticks while the display is live.
  task automatic push_live(input int from, input int to);
    exp_t e;
    for (int v = from; v <= to; v++) begin
      e.q1   = 3'((v % 60) / 10);
      e.q0   = 4'((v % 60) % 10);
      e.wrap = ((v % 60) == 0);
      sb.push_back(e);
    end
  endtask

  // Expected display on successive ticks while the lap snapshot is shown.
  task automatic push_held(input int n, input int h1, input int h0);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.q1   = 3'(h1);
      e.q0   = 4'(h0);
      e.wrap = 1'b0;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && tick) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_tick: got tick=1 q1=%0d q0=%0d expected no tick", q1, q0);
      end else begin
        mon_e = sb.pop_front();
        if ({q1, q0, wrap} !== mon_e) begin
          errors++;
          $display("FAIL sb_tick: got q1=%0d q0=%0d wrap=%0d expected q1=%0d q0=%0d wrap=%0d",
                   q1, q0, wrap, mon_e.q1, mon_e.q0, mon_e.wrap);
        end
      end
    end else if (!rst && wrap) begin
      checks++;
      errors++;
      $display("FAIL sb_wrap_without_tick: got wrap=1 tick=0 expected wrap only with tick");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    step(3);
    chk("rst_q0", q0, 0);
    chk("rst_q1", q1, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_state", state, 0);
    rst = 1'b0;
    step(2);

    // Run: 60 ticks from 00 back to 00 with wrap.
    push_live(1, 60);
    btn_start = 1'b1;
    step(3);
    chk("run_pre_state", state, 0);
    step(1);
    chk("run_state", state, 1);
    btn_start = 1'b0;
    step(3);
    chk("first_tick_early", tick, 0);
    step(1);
    chk("first_tick", tick, 1);
    chk("first_q0", q0, 1);
    step(4 * 59);
    chk("wrap_q0", q0, 0);
    chk("wrap_q1", q1, 0);
    chk("wrap_pulse", wrap, 1);
    step(1);
    chk("wrap_one_cycle", wrap, 0);

    // Pause at 07 with prescaler held at 2, then resume.
    push_live(1, 7);
    step(25);
    btn_start = 1'b1;
    step(4);
    chk("pause_state", state, 2);
    chk("pause_q0", q0, 7);
    chk("pause_q1", q1, 0);
    btn_start = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (tick) n++;
    end
    chk("pause_no_tick", n, 0);
    chk("pause_hold_q0", q0, 7);
    chk("pause_hold_state", state, 2);
    push_live(8, 8);
    btn_start = 1'b1;
    step(3);
    chk("resume_pre_state", state, 2);
    step(1);
    chk("resume_state", state, 1);
    btn_start = 1'b0;
    step(1);
    chk("resume_tick_early", tick, 0);
    step(1);
    chk("resume_tick", tick, 1);
    chk("resume_q0", q0, 8);

    // clr ignored in RUN at 23; start coinciding with a tick still ticks then pauses.
    push_live(9, 25);
    step(57);
    btn_clr = 1'b1;
    step(4);
    chk("clr_run_state", state, 1);
    chk("clr_run_q0", q0, 3);
    chk("clr_run_q1", q1, 2);
    btn_clr = 1'b0;
    step(3);
    chk("after_clr_tick", tick, 1);
    chk("after_clr_q0", q0, 4);
    chk("after_clr_q1", q1, 2);
    btn_start = 1'b1;
    step(4);
    chk("start_on_tick_tick", tick, 1);
    chk("start_on_tick_q0", q0, 5);
    chk("start_on_tick_state", state, 2);
    btn_start = 1'b0;
    step(3);
    btn_clr = 1'b1;
    step(4);
    chk("clr_pause_state", state, 0);
    chk("clr_pause_q0", q0, 0);
    chk("clr_pause_q1", q1, 0);
    btn_clr = 1'b0;
    step(3);

    // Same-cycle clr+start in PAUSE: clr wins.
    push_live(1, 1);
    btn_start = 1'b1;
    step(4);
    chk("run2_state", state, 1);
    btn_start = 1'b0;
    step(2);
    btn_start = 1'b1;
    step(4);
    chk("pause2_state", state, 2);
    chk("pause2_q0", q0, 1);
    btn_start = 1'b0;
    step(3);
    btn_start = 1'b1;
    btn_clr   = 1'b1;
    step(4);
    chk("clr_beats_start_state", state, 0);
    chk("clr_beats_start_q0", q0, 0);
    btn_start = 1'b0;
    btn_clr   = 1'b0;
    step(3);

`ifdef STOPWATCH_LAP_EN
    // Lap at 14, live runs on to 24 underneath, second lap shows 24, then lap again at 41.
    push_live(1, 14);
    push_held(10, 1, 4);
    push_live(25, 41);
    btn_start = 1'b1;
    step(4);
    chk("lap_run_state", state, 1);
    btn_start = 1'b0;
    step(53);
    btn_lap = 1'b1;
    step(4);
    chk("lap_state", state, 3);
    chk("lap_q0", q0, 4);
    chk("lap_q1", q1, 1);
    btn_lap = 1'b0;
    step(36);
    btn_lap = 1'b1;
    step(3);
    chk("lap_hold_tick", tick, 1);
    chk("lap_hold_q0", q0, 4);
    chk("lap_hold_q1", q1, 1);
    step(1);
    chk("lap_exit_state", state, 1);
    chk("lap_exit_q0", q0, 4);
    chk("lap_exit_q1", q1, 2);
    btn_lap = 1'b0;
    step(65);
    btn_lap = 1'b1;
    step(4);
    chk("lap2_state", state, 3);
    chk("lap2_q0", q0, 1);
    chk("lap2_q1", q1, 4);
    btn_lap = 1'b0;
`else
    // Lap button has no effect without the lap feature.
    push_live(1, 3);
    btn_start = 1'b1;
    step(4);
    chk("nolap_run_state", state, 1);
    btn_start = 1'b0;
    step(2);
    btn_lap = 1'b1;
    step(4);
    chk("nolap_state", state, 1);
    chk("nolap_q0", q0, 1);
    btn_lap = 1'b0;
    step(6);
    chk("nolap_state2", state, 1);
    chk("nolap_tick", tick, 1);
    chk("nolap_q0_live", q0, 3);
    step(1);
`endif

    // Asynchronous reset between clock edges.
    #3;
    rst = 1'b1;
    #1;
    chk("arst_q0", q0, 0);
    chk("arst_q1", q1, 0);
    chk("arst_tick", tick, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_state", state, 0);
    chk("arst_sb_empty", sb.size(), 0);
    step(1);
    rst = 1'b0;

    // Held-high start after reset yields exactly one start event.
    push_live(1, 5);
    btn_start = 1'b1;
    step(4);
    chk("held_state", state, 1);
    step(20);
    chk("held_state_stays", state, 1);
    chk("held_q0", q0, 5);
    step(1);
    chk("final_sb_empty", sb.size(), 0);
    btn_start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
